// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory for the MEM stage with a
// configurable wait-state count and a pipeline stall output.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses
// (addr_err pulse, store suppressed, load data forced to zero).
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        addr_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic                    mis_q, mis_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    addr_err_q, addr_err_d;
    logic                    mem_we;
    logic                    req_mis;
    logic                    unused_addr;
    logic [31:0]             mem [2**DEPTH_LOG2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_mis = req_addr[1:0] != 2'b00;
`else
    assign req_mis = 1'b0;
`endif

    // Upper address bits wrap the memory; byte-offset bits only matter for the align check.
    assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

    assign mem_stall = req_valid & ~rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr_err  = addr_err_q;

    // Next-state logic: latch the request in IDLE, count wait states, do the access on the last one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mis_d       = mis_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        addr_err_d  = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY);
                we_d    = req_we;
                mis_d   = req_mis;
                idx_d   = req_addr[DEPTH_LOG2+1:2];
                wdata_d = req_wdata;
            end
            BUSY: if (cnt_q == 4'd0) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                addr_err_d  = mis_q;
                rsp_rdata_d = (we_q || mis_q) ? 32'h0 : mem[idx_q];
                mem_we      = we_q & ~mis_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mis_q       <= mis_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 2 and 0.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv  [2];
    logic        rwe [2];
    logic [31:0] ra  [2];
    logic [31:0] rwd [2];
    logic        stall [2];
    logic        rsp   [2];
    logic [31:0] rdat  [2];
    logic        aerr  [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(ra[0]),
        .req_wdata(rwd[0]), .mem_stall(stall[0]), .rsp_valid(rsp[0]),
        .rsp_rdata(rdat[0]), .addr_err(aerr[0]));

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(ra[1]),
        .req_wdata(rwd[1]), .mem_stall(stall[1]), .rsp_valid(rsp[1]),
        .rsp_rdata(rdat[1]), .addr_err(aerr[1]));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Starts just after a rising edge; returns just after the edge that ends the rsp cycle.
    task automatic access(input int s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int stalls,
                          output logic stall_at_rsp);
        lat = -1; stalls = 0; rdata = 'x; err = 'x; stall_at_rsp = 'x;
        rv[s] = 1'b1; rwe[s] = we; ra[s] = addr; rwd[s] = wdata;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp[s]) begin
                lat = n; rdata = rdat[s]; err = aerr[s]; stall_at_rsp = stall[s];
                break;
            end
            if (stall[s]) stalls++;
        end
        if (lat < 0) chk("rsp_timeout", 32'(lat), 32'h0);
        @(posedge clk); #1;
        rv[s] = 1'b0;
    endtask

    vec_t        vec [9];
    logic [31:0] rd;
    logic        er, sr;
    int          lt, st;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rwe[i] = 1'b0; ra[i] = 32'h0; rwd[i] = 32'h0;
        end
        vec[0] = '{1'b1, 32'h0000_0084, 32'h0000_0084, 32'h0, 1'b0};
        vec[1] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vec[2] = '{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vec[3] = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b0};
        vec[4] = '{1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0};
        vec[6] = '{1'b1, 32'h0000_07FC, 32'h0102_0304, 32'h0, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vec[5] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vec[7] = '{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vec[8] = '{1'b0, 32'h0000_03FD, 32'h0, 32'h0, 1'b1};
`else
        vec[5] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vec[7] = '{1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_FFFF, 1'b0};
        vec[8] = '{1'b0, 32'h0000_03FD, 32'h0, 32'h0102_0304, 1'b0};
`endif
        #1;
        chk("reset_rsp_valid", 32'(rsp[0]), 32'h0);
        chk("reset_addr_err", 32'(aerr[0]), 32'h0);
        chk("reset_rdata", rdat[0], 32'h0);
        chk("reset_stall_l0", 32'(rsp[1]), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            access(0, vec[i].we, vec[i].addr, vec[i].wdata, rd, er, lt, st, sr);
            chk($sformatf("v%0d_latency", i), 32'(lt), 32'd4);
            chk($sformatf("v%0d_stall_cycles", i), 32'(st), 32'd4);
            chk($sformatf("v%0d_stall_at_rsp", i), 32'(sr), 32'h0);
            chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
            chk($sformatf("v%0d_addr_err", i), 32'(er), 32'(vec[i].exp_err));
        end
        chk("rsp_valid_one_cycle", 32'(rsp[0]), 32'h0);
        chk("rdata_held", rdat[0], vec[8].exp_rdata);

        // Reset in the middle of a store's wait states discards the store.
        access(0, 1'b1, 32'h10, 32'h1111_1111, rd, er, lt, st, sr);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lt, st, sr);
        chk("pre_reset_load", rd, 32'h1111_1111);
        rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 32'h10; rwd[0] = 32'h2222_2222;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; rv[0] = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp[0]), 32'h0);
        chk("midreset_addr_err", 32'(aerr[0]), 32'h0);
        chk("midreset_rdata", rdat[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lt, st, sr);
        chk("postreset_load", rd, 32'h1111_1111);
        chk("postreset_latency", 32'(lt), 32'd4);

        // Request inputs churn during wait states; only the accepted values count.
        rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 32'h80; rwd[0] = 32'hA5A5_A5A5;
        lt = -1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (rsp[0]) begin lt = n; break; end
            ra[0]  = 32'h84 + 32'(n % 2) * 32'h4;
            rwd[0] = 32'h5A5A_0000 + 32'(n);
            rwe[0] = n[0];
        end
        chk("churn_latency", 32'(lt), 32'd3);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        access(0, 1'b0, 32'h80, 32'h0, rd, er, lt, st, sr);
        chk("churn_word80", rd, 32'hA5A5_A5A5);
        access(0, 1'b0, 32'h84, 32'h0, rd, er, lt, st, sr);
        chk("churn_word84", rd, 32'h0000_0084);

        // Zero wait states, back-to-back loads with the mandatory idle cycle between.
        access(1, 1'b1, 32'h0, 32'h0BAD_F00D, rd, er, lt, st, sr);
        chk("l0_store_latency", 32'(lt), 32'd2);
        access(1, 1'b1, 32'h4, 32'hCAFE_F00D, rd, er, lt, st, sr);
        access(1, 1'b0, 32'h0, 32'h0, rd, er, lt, st, sr);
        chk("l0_load0_latency", 32'(lt), 32'd2);
        chk("l0_load0_stalls", 32'(st), 32'd2);
        chk("l0_load0_rdata", rd, 32'h0BAD_F00D);
        access(1, 1'b0, 32'h4, 32'h0, rd, er, lt, st, sr);
        chk("l0_load4_latency", 32'(lt), 32'd2);
        chk("l0_load4_rdata", rd, 32'hCAFE_F00D);
        chk("l0_load4_stall_at_rsp", 32'(sr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core. It sits on the far side of the MEM-stage load/store port and services one word access at a time, with a configurable wait-state count. While an access is in flight it drives a stall back to the pipeline. It replaces the zero-latency data RAM so the pipeline's stall and forwarding paths are exercised against realistic memory timing.

## Interface

Parameters:
- DEPTH_LOG2, 8: log2 of word count (256 words of 32 bits).
- LATENCY, 2: wait states per access, legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM stage holds a load or store request. Held stable until rsp_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALUOut of the MEM stage).
- req_wdata  in  32  store data, already forwarded.
- mem_stall  out  1  combinational: req_valid & ~rsp_valid. Freezes F, D, E and M; bubbles W.
- rsp_valid  out  1  registered one-cycle pulse: access complete.
- rsp_rdata  out  32  load data, valid while rsp_valid = 1.
- addr_err  out  1  registered; pulses with rsp_valid on a misaligned access.

## Operation

- Storage: 2^DEPTH_LOG2 words. Word index = req_addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size. Contents are not reset.
- FSM states:
  - IDLE: if req_valid, latch we, addr and wdata, load cnt = LATENCY, go to BUSY.
  - BUSY: if cnt == 0, perform the access (write the array, or read into rsp_rdata) and go to RESP. Otherwise cnt <= cnt - 1.
  - RESP: rsp_valid = 1, then go to IDLE unconditionally.
- Only latched values are used after IDLE. Changes on req_* inputs during BUSY or RESP are ignored.
- Store: the array is updated at the BUSY→RESP edge, and rsp_rdata <= 0.
- Load: rsp_rdata <= array[index] at the BUSY→RESP edge. The value is held until the next access completes.
- After RESP the FSM passes through IDLE, so back-to-back requests always see a one-cycle gap.
- Reset values: state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, addr_err 0.
- Reset mid-access returns the FSM to IDLE. A pending store is discarded, and the array is unmodified unless the BUSY→RESP edge had already occurred.
- req_valid deasserting during BUSY is a protocol violation. The access still completes and rsp_valid still pulses.

## Timing

- req_valid first sampled in IDLE at edge E0 → rsp_valid is high during the cycle after edge E0+LATENCY+1.
- Total occupancy is LATENCY+3 cycles from acceptance back to IDLE.
- LATENCY=0: req_valid high in cycle 0 → rsp_valid high in cycle 2 → IDLE in cycle 3.
- mem_stall is high in cycles 0..LATENCY+1 and low in the rsp_valid cycle, so the pipeline advances at that cycle's edge.
- A new request seen in the cycle after RESP is accepted there (IDLE).
- Store data is visible to a load accepted any time after the completing RESP.

## Configuration

- DMEM_ALIGN_CHECK_EN defined:
  - req_addr[1:0] != 0 makes addr_err pulse with rsp_valid.
  - A misaligned store does not modify the array.
  - A misaligned load returns rsp_rdata = 0.
  - Timing is unchanged.
- Not defined:
  - req_addr[1:0] is ignored, and misaligned accesses behave as aligned.
  - addr_err is tied to 0.

## Test plan

- Reset/idle: assert rst mid-BUSY of a store to 0x10 with LATENCY=2 → rsp_valid, addr_err and rsp_rdata are all 0 immediately. A later load of 0x10 returns the prior contents.
- Store then load, LATENCY=2: store 0xDEADBEEF to 0x40, then load 0x40.
  - Each access gives rsp_valid exactly 4 cycles after req_valid.
  - mem_stall is high for 4 cycles, then low in the rsp_valid cycle.
  - The load returns 0xDEADBEEF.
- LATENCY=0 back-to-back: load 0x0, then load 0x4 the cycle after the first rsp_valid.
  - rsp_valid arrives 2 cycles after each request.
  - There is a 1-cycle IDLE gap between the accesses.
- Wrap-around, DEPTH_LOG2=8: store 0x12345678 to 0x400, then load 0x0 → 0x12345678.
- Misaligned, with DMEM_ALIGN_CHECK_EN:
  - Store 0xFFFFFFFF to 0x42 → addr_err pulse, and word 0x40 is unchanged.
  - Without the macro, the same store writes word 0x40 and addr_err stays 0.
- Input churn: change req_addr and req_wdata every cycle during BUSY of a store to 0x80 with value 0xA5A5A5A5 → only word 0x80 is written, with 0xA5A5A5A5.
